// File: rtl/dnn_pkg.sv
// Shared digit-recognition datapath definitions: class count, float8 layout,
// argmax FSM state encodings and the float8 ordering key.
package dnn_pkg;

  localparam int N_CLASSES = 10;
  localparam int FW        = 8;
  localparam int IDX_W     = 4;

  // Sign-magnitude float8; exponent above mantissa keeps the magnitude monotonic.
  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [2:0] man;
  } float8_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SCAN = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Signed ordering key; -0 and +0 both map to 0.
  function automatic logic signed [8:0] float8_key(input float8_t f);
    logic signed [8:0] mag;
    mag = {2'b00, f.exp, f.man};
    return f.sign ? -mag : mag;
  endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Handshake and data bundle between the FC2 stage (master) and the argmax stage (slave).
interface argmax_classifier_if;
  import dnn_pkg::*;

  logic                      ena;
  logic                      start;
  logic [N_CLASSES*FW-1:0]   scores_in;
  logic                      overflow_in;
  logic                      busy;
  logic                      done;
  logic [IDX_W-1:0]          digit;
  logic [FW-1:0]             max_score;
  logic                      overflow;
  logic                      low_conf;

  modport master (
    output ena, start, scores_in, overflow_in,
    input  busy, done, digit, max_score, overflow, low_conf
  );

  modport slave (
    input  ena, start, scores_in, overflow_in,
    output busy, done, digit, max_score, overflow, low_conf
  );

endinterface

// File: rtl/float8_cmp.sv
// Combinational strict greater-than on two float8 values (-0 equals +0).
module float8_cmp
  import dnn_pkg::*;
(
  input  float8_t a,
  input  float8_t b,
  output logic    a_gt_b
);

  assign a_gt_b = float8_key(a) > float8_key(b);

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over the FC2 class scores, one score per clock.
// Optional low-confidence flag enabled by defining ARGMAX_CONFIDENCE_EN.
module argmax_classifier
  import dnn_pkg::*;
(
  input  logic                clk,
  input  logic                iRst_n,
  argmax_classifier_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  logic [1:0]                  state;
  float8_t [N_CLASSES-1:0]     scores_q;
  logic [IDX_W-1:0]            scan_idx;
  float8_t                     best_q;
  logic [IDX_W-1:0]            best_idx;
  logic [IDX_W-1:0]            digit_q;
  float8_t                     max_q;
  logic                        overflow_q;

  float8_t                     cur;
  logic                        cur_gt_best;
  float8_t                     best_nxt;
  logic [IDX_W-1:0]            idx_nxt;

  logic start_load;
  logic scan_step;
  logic scan_last;

  assign start_load = bus.ena && bus.start && (state == ST_IDLE || state == ST_DONE);
  assign scan_step  = bus.ena && (state == ST_SCAN);
  assign scan_last  = scan_step && (scan_idx == LAST_IDX);
  assign cur        = scores_q[scan_idx];

  float8_cmp u_cmp_best (
    .a      (cur),
    .b      (best_q),
    .a_gt_b (cur_gt_best)
  );

  // NOTE: defaults first so every path assigns, otherwise a latch is inferred.
  always_comb begin
    best_nxt = best_q;
    idx_nxt  = best_idx;
    if (cur_gt_best) begin
      best_nxt = cur;
      idx_nxt  = scan_idx;
    end
  end

  // NOTE: the score latch is always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (start_load) scores_q <= bus.scores_in;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= ST_IDLE;
      scan_idx   <= '0;
      best_q     <= '0;
      best_idx   <= '0;
      digit_q    <= '0;
      max_q      <= '0;
      overflow_q <= 1'b0;
    end else if (!bus.ena) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state      <= ST_SCAN;
            best_q     <= bus.scores_in[FW-1:0];
            best_idx   <= '0;
            scan_idx   <= IDX_W'(1);
            overflow_q <= bus.overflow_in;
          end
        end
        ST_SCAN: begin
          best_q   <= best_nxt;
          best_idx <= idx_nxt;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) begin
            state   <= ST_DONE;
            digit_q <= idx_nxt;
            max_q   <= best_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ST_SCAN);
  assign bus.done      = (state == ST_DONE);
  assign bus.digit     = digit_q;
  assign bus.max_score = max_q;
  assign bus.overflow  = overflow_q;

`ifdef ARGMAX_CONFIDENCE_EN
  localparam logic [7:0] CONF_MARGIN = 8'd8;

  float8_t           second_q;
  logic              second_vld;
  logic              cur_gt_second;
  float8_t           second_nxt;
  logic signed [8:0] best_key;
  logic signed [8:0] second_key;
  logic [9:0]        margin;
  logic              low_conf_q;

  float8_cmp u_cmp_second (
    .a      (cur),
    .b      (second_q),
    .a_gt_b (cur_gt_second)
  );

  // A displaced best becomes the runner-up; score0 is never its own runner-up.
  always_comb begin
    second_nxt = second_q;
    if (cur_gt_best)                      second_nxt = best_q;
    else if (!second_vld || cur_gt_second) second_nxt = cur;
    best_key   = float8_key(best_nxt);
    second_key = float8_key(second_nxt);
    margin     = {best_key[8], best_key} - {second_key[8], second_key};
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      second_q   <= '0;
      second_vld <= 1'b0;
      low_conf_q <= 1'b0;
    end else if (start_load) begin
      second_vld <= 1'b0;
    end else if (scan_step) begin
      second_q   <= second_nxt;
      second_vld <= 1'b1;
      if (scan_last) low_conf_q <= (margin < {2'b00, CONF_MARGIN});
    end
  end

  assign bus.low_conf = low_conf_q;
`else
  assign bus.low_conf = 1'b0;
`endif

endmodule
